// File: rtl/q_sys_irq_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt aggregator.
package q_sys_irq_pkg;

  localparam int MAX_SRC = 16;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd5;
  localparam logic [2:0] ADDR_EVCOUNT = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERTED = 2'd1,
    HOLDOFF  = 2'd2
  } irq_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set_idx(input logic [MAX_SRC-1:0] v);
    lowest_set_idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = 4'(i);
    end
  endfunction

endpackage

// File: rtl/q_sys_irq_holdoff.sv
// Output interrupt sequencer: registered irq with a programmable minimum low gap.
// state    | meaning
// IDLE     | irq low, waiting for a request
// ASSERTED | irq high until the request drops
// HOLDOFF  | irq low, cnt counts down the minimum gap before re-arming
module q_sys_irq_holdoff
  import q_sys_irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_req,
  input  logic [15:0] holdoff,
  output logic        irq,
  output logic        rise
);

  irq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (irq_req) begin
          state_d = ASSERTED;
          rise    = 1'b1;
        end
      end
      ASSERTED: begin
        if (!irq_req) begin
          if (holdoff == 16'd0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            cnt_d   = holdoff;
          end
        end
      end
      HOLDOFF: begin
        // cnt is latched on entry, so later HOLDOFF writes only affect the next gap
        if (cnt_q == 16'd1) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq     <= (state_d == ASSERTED);
    end
  end

endmodule

// File: rtl/q_sys_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source mask and level/edge select, W1C edge
// latches, lowest-index vector, rate-limited CPU irq and a saturating event counter.
module q_sys_irq_aggregator
  import q_sys_irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq
);

  logic             wr;
  logic             wr_pending, wr_enable, wr_edge, wr_holdoff, wr_evcount;
  logic [N_SRC-1:0] irq_in_q;
  logic [N_SRC-1:0] edge_lat_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] rise_src, w1c;
  logic [N_SRC-1:0] pending, active;
  logic [15:0]      holdoff_q;
  logic [15:0]      evcount_q;
  logic [15:0]      rd_mux;
  logic [MAX_SRC-1:0] pending_w, enable_w, edge_w, active_w;
  logic             irq_req;
  logic             irq_rise;

  assign wr         = chipselect & ~write_n;
  assign wr_pending = wr & (address == ADDR_PENDING);
  assign wr_enable  = wr & (address == ADDR_ENABLE);
  assign wr_edge    = wr & (address == ADDR_EDGE);
  assign wr_holdoff = wr & (address == ADDR_HOLDOFF);
  assign wr_evcount = wr & (address == ADDR_EVCOUNT);

  assign edge_d   = wr_edge ? writedata[N_SRC-1:0] : edge_q;
  assign rise_src = irq_in & ~irq_in_q;
  assign w1c      = wr_pending ? writedata[N_SRC-1:0] : '0;
  assign pending  = edge_lat_q | (~edge_q & irq_in_q);
  assign active   = pending & enable_q;
  assign irq_req  = |active;

  // Zero-extend to the full register width so unused upper bits read 0.
  always_comb begin
    pending_w = '0;
    enable_w  = '0;
    edge_w    = '0;
    active_w  = '0;
    pending_w[N_SRC-1:0] = pending;
    enable_w[N_SRC-1:0]  = enable_q;
    edge_w[N_SRC-1:0]    = edge_q;
    active_w[N_SRC-1:0]  = active;
  end

  // Loaded even in reset so a source held high across reset is not seen as an edge.
  always_ff @(posedge clk) begin
    irq_in_q <= irq_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q   <= '0;
      edge_q     <= '0;
      edge_lat_q <= '0;
      holdoff_q  <= 16'd0;
    end else begin
      if (wr_enable)  enable_q  <= writedata[N_SRC-1:0];
      if (wr_holdoff) holdoff_q <= writedata;
      edge_q <= edge_d;
      // Set beats W1C; a latch only survives while its source stays edge-mode
      // across this cycle, so toggling EDGE in either direction starts it clear.
      edge_lat_q <= (rise_src | (edge_lat_q & ~w1c)) & edge_q & edge_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evcount_q <= 16'd0;
    end else if (wr_evcount) begin
      evcount_q <= irq_rise ? 16'd1 : 16'd0;
    end else if (irq_rise && (evcount_q != 16'hFFFF)) begin
      evcount_q <= evcount_q + 16'd1;
    end
  end

  q_sys_irq_holdoff u_holdoff (
    .clk     (clk),
    .reset   (reset),
    .irq_req (irq_req),
    .holdoff (holdoff_q),
    .irq     (irq),
    .rise    (irq_rise)
  );

  always_comb begin
    rd_mux = 16'd0;
    case (address)
      ADDR_PENDING: rd_mux = pending_w;
      ADDR_ENABLE:  rd_mux = enable_w;
      ADDR_EDGE:    rd_mux = edge_w;
      ADDR_ACTIVE:  rd_mux = active_w;
      ADDR_VECTOR:  rd_mux = (|active_w) ? {1'b1, 11'd0, lowest_set_idx(active_w)} : 16'd0;
      ADDR_HOLDOFF: rd_mux = holdoff_q;
      ADDR_EVCOUNT: rd_mux = evcount_q;
      default:      rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= 16'd0;
    else       readdata <= rd_mux;
  end

endmodule
